iss_cmd_driver: RTL and testbench
=================================

// Module: iss_cmd_driver
// PURPOSE
//  AGC-side driver for the CDU digital-mode interface: issues the ISS discretes
//  (coarse align, zero, error-counter enable) and emits per-axis +/- error-counter
//  drive pulse trains (A/B/C) into the CDU. It accepts one signed pulse-count command at
//  a time and paces pulses at a fixed slot rate. The CDU's UINHRC gates the slot timing.
// PARAMETERS
//  SLOT_CLKS   16  clocks per pulse slot (>= PW+2)
//  PW          2   drive pulse high time, clocks (>= 1)
//  ZERO_CLKS   64  clocks ISSZ is held high per zero request (>= 1)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst_n       in   1   synchronous reset, active low
//  disc_we     in   1   write ISS discrete register
//  disc_data   in   3   {eec, ca, zreq}
//  cmd_valid   in   1   command offered
//  cmd_ready   out  1   driver can accept a command
//  cmd_axis    in   2   0=A 1=B 2=C 3=illegal
//  cmd_neg     in   1   1 = minus pulses
//  cmd_mag     in   15  pulse count magnitude
//  cmd_abort   in   1   stop after the pulse in flight
//  UINHRC      in   1   CDU inhibit-counting; suppresses pulse emission
//  ISSCA       out  1   coarse-align discrete to CDU
//  ISSZ        out  1   ISS zero discrete to CDU
//  ISSEEC      out  1   error-counter enable discrete to CDU
//  pls_p       out  3   plus drive pulses {C,B,A}
//  pls_m       out  3   minus drive pulses {C,B,A}
//  remaining   out  15  pulses still to send for the active command
//  done        out  1   1-clock strobe: command finished (complete, aborted or rejected)
//  err         out  1   1-clock strobe with done: illegal axis
// BEHAVIOUR
//  Reset: all outputs 0 except cmd_ready=1; state IDLE, slot counter 0.
//  Discretes: on disc_we, ISSCA<=ca, ISSEEC<=eec the next edge (1 clk latency).
//   zreq=1 with state IDLE -> state ZERO, ISSZ=1 from next edge for exactly ZERO_CLKS
//   clocks, then ISSZ=0, back to IDLE. zreq ignored unless IDLE (ca/eec still written).
//  States: IDLE, ZERO, DRIVE, TAIL.
//  cmd_ready = (state==IDLE) & ~ISSZ. Accept = cmd_valid & cmd_ready; disc_we zreq and
//   accept same clock -> zero wins, command not accepted (cmd_ready drops next edge).
//  On accept: axis 3 -> done=1 and err=1 next clock, stay IDLE. mag 0 -> done=1 next
//   clock, stay IDLE. Else latch axis/sign, remaining<=mag, slot counter<=0, DRIVE.
//  DRIVE: slot counter counts 0..SLOT_CLKS-1, wraps. At count 0 a pulse is emitted iff
//   UINHRC=0 and ISSEEC=1; else slot is skipped, remaining unchanged.
//   Emitted pulse: selected pls_p/pls_m bit high for counts 0..PW-1; remaining
//   decrements on the edge ending count PW-1. Only one of the six lines is ever high.
//  When remaining reaches 0 -> TAIL; TAIL waits to end of current slot (line low for
//   >= SLOT_CLKS-PW clocks), then done=1 one clock, IDLE.
//  cmd_abort in DRIVE: pulse in flight (if any) completes at full width; no further
//   pulses; go TAIL; remaining holds value left (not cleared) until next accept.
//  UINHRC or ISSEEC changing mid-pulse does not truncate that pulse.
//  Discrete writes during DRIVE update ISSCA/ISSEEC immediately (gate next slot).
//  remaining is 15-bit unsigned; never wraps below 0.
//  rst_n low in any state: all outputs to reset values next edge, pulse cut off.
// TESTING
//  Reset, disc_we {1,1,0} -> ISSEEC=1, ISSCA=1 one clock later; all pulses 0.
//  cmd A, neg=0, mag=3, ISSEEC=1 -> 3 PW-wide pls_p[0] pulses SLOT_CLKS apart;
//   remaining 3,2,1,0; done one clock, ~SLOT_CLKS after last pulse start.
//  cmd C neg=1 mag=5, UINHRC high for slots 2-3 -> pls_m[2] pulses in slots 0,1,4,5,6.
//  zreq write -> ISSZ high exactly 64 clocks, cmd_ready=0 throughout, 1 after.
//  cmd axis=3 -> done & err same clock, no pulses; mag=0 -> done only.
//  cmd B mag=100, abort mid-pulse 4 -> pulse 4 full width, done; remaining=96.

Source files
------------

// File: rtl/iss_cmd_driver_if.sv
// Command handshake between the AGC-side sequencer and the ISS/CDU pulse driver.
// The sequencer uses the master view and the driver uses the slave view.
interface iss_cmd_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_axis;
  logic        cmd_neg;
  logic [14:0] cmd_mag;
  logic        cmd_abort;
  logic [14:0] remaining;
  logic        done;
  logic        err;

  modport master (
    output cmd_valid, cmd_axis, cmd_neg, cmd_mag, cmd_abort,
    input  cmd_ready, remaining, done, err
  );

  modport slave (
    input  cmd_valid, cmd_axis, cmd_neg, cmd_mag, cmd_abort,
    output cmd_ready, remaining, done, err
  );
endinterface

// File: rtl/iss_cmd_driver.sv
// CDU digital-mode driver: holds the ISS discretes and paces signed per-axis
// error-counter pulse trains at a fixed slot rate, gated by UINHRC and ISSEEC.
module iss_cmd_driver #(
  parameter int unsigned SLOT_CLKS = 16,
  parameter int unsigned PW        = 2,
  parameter int unsigned ZERO_CLKS = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disc_we,
  input  logic [2:0]       disc_data,
  input  logic             UINHRC,
  output logic             ISSCA,
  output logic             ISSZ,
  output logic             ISSEEC,
  output logic [2:0]       pls_p,
  output logic [2:0]       pls_m,
  iss_cmd_driver_if.slave  cmd
);

  localparam int unsigned SW = $clog2(SLOT_CLKS);
  localparam int unsigned ZW = $clog2(ZERO_CLKS + 1);
  localparam logic [SW-1:0] SlotLast = SW'(SLOT_CLKS - 1);
  localparam logic [SW-1:0] PwLast   = SW'(PW - 1);
  localparam logic [ZW-1:0] ZeroLast = ZW'(ZERO_CLKS - 1);

  typedef enum logic [1:0] {StIdle, StZero, StDrive, StTail} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] slot_q, slot_d;
  logic [ZW-1:0] zcnt_q, zcnt_d;
  logic [1:0]    axis_q, axis_d;
  logic          neg_q, neg_d;
  logic          fire_q, fire_d;
  logic          abort_q, abort_d;
  logic [14:0]   rem_q, rem_d;
  logic          issca_q, issca_d;
  logic          isseec_q, isseec_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic zreq, fire_now, pulse_act, pulse_end, stop_req, go_tail;

  assign zreq     = disc_we & disc_data[0];
  assign fire_now = ~UINHRC & isseec_q;
  assign stop_req = abort_q | cmd.cmd_abort;
  // Slot gating is decided live at count 0, then latched so late UINHRC/ISSEEC
  // changes cannot truncate a pulse already on the line.
  assign pulse_act = (state_q == StDrive) &
                     ((slot_q == '0) ? fire_now : (fire_q & (slot_q <= PwLast)));
  assign pulse_end = pulse_act & (slot_q == PwLast);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      slot_q   <= '0;
      zcnt_q   <= '0;
      axis_q   <= '0;
      neg_q    <= 1'b0;
      fire_q   <= 1'b0;
      abort_q  <= 1'b0;
      rem_q    <= '0;
      issca_q  <= 1'b0;
      isseec_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      zcnt_q   <= zcnt_d;
      axis_q   <= axis_d;
      neg_q    <= neg_d;
      fire_q   <= fire_d;
      abort_q  <= abort_d;
      rem_q    <= rem_d;
      issca_q  <= issca_d;
      isseec_q <= isseec_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    zcnt_d   = zcnt_q;
    axis_d   = axis_q;
    neg_d    = neg_q;
    fire_d   = fire_q;
    abort_d  = abort_q;
    rem_d    = rem_q;
    issca_d  = issca_q;
    isseec_d = isseec_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    go_tail  = 1'b0;

    if (disc_we) begin
      issca_d  = disc_data[1];
      isseec_d = disc_data[2];
    end

    unique case (state_q)
      StIdle: begin
        slot_d = '0;
        // A zero request in the same clock as an offered command takes priority.
        if (zreq) begin
          state_d = StZero;
          zcnt_d  = '0;
        end else if (cmd.cmd_valid) begin
          if (cmd.cmd_axis == 2'd3) begin
            done_d = 1'b1;
            err_d  = 1'b1;
          end else if (cmd.cmd_mag == '0) begin
            done_d = 1'b1;
          end else begin
            axis_d  = cmd.cmd_axis;
            neg_d   = cmd.cmd_neg;
            rem_d   = cmd.cmd_mag;
            fire_d  = 1'b0;
            abort_d = 1'b0;
            state_d = StDrive;
          end
        end
      end

      StZero: begin
        if (zcnt_q == ZeroLast) state_d = StIdle;
        else                    zcnt_d  = zcnt_q + 1'b1;
      end

      StDrive: begin
        slot_d  = (slot_q == SlotLast) ? '0 : slot_q + 1'b1;
        abort_d = stop_req;
        if (slot_q == '0) fire_d = fire_now;
        if (pulse_end) begin
          rem_d   = rem_q - 1'b1;
          go_tail = (rem_q == 15'd1) | stop_req;
        end else if (!pulse_act) begin
          go_tail = stop_req;
        end
        if (go_tail) begin
          // Stopping on the last count of a slot already ends that slot.
          if (slot_q == SlotLast) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StTail;
          end
        end
      end

      StTail: begin
        slot_d = (slot_q == SlotLast) ? '0 : slot_q + 1'b1;
        if (slot_q == SlotLast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    logic [2:0] sel;
    sel           = 3'b001 << axis_q;
    ISSCA         = issca_q;
    ISSEEC        = isseec_q;
    ISSZ          = (state_q == StZero);
    cmd.cmd_ready = (state_q == StIdle) & ~ISSZ;
    cmd.remaining = rem_q;
    cmd.done      = done_q;
    cmd.err       = err_q;
    pls_p         = (pulse_act & ~neg_q) ? sel : 3'b000;
    pls_m         = (pulse_act &  neg_q) ? sel : 3'b000;
  end

endmodule

// File: tb/tb_iss_cmd_driver.sv
// Randomised scoreboard bench for iss_cmd_driver: stimulus pushes predicted pulse
// and done events, a negedge monitor pops and compares what the driver emits.
module tb_iss_cmd_driver;
  localparam int SLOT  = 16;
  localparam int PW    = 2;
  localparam int ZC    = 64;
  localparam int NSLOT = 128;

  typedef struct packed {
    logic       is_done;
    int         cyc;
    logic [5:0] vec;
    int         width;
    int         rem;
    logic       err;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       disc_we;
  logic [2:0] disc_data;
  logic       UINHRC;
  logic       ISSCA, ISSZ, ISSEEC;
  logic [2:0] pls_p, pls_m;

  iss_cmd_driver_if cmd_if ();

  iss_cmd_driver #(
    .SLOT_CLKS (SLOT),
    .PW        (PW),
    .ZERO_CLKS (ZC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .disc_we   (disc_we),
    .disc_data (disc_data),
    .UINHRC    (UINHRC),
    .ISSCA     (ISSCA),
    .ISSZ      (ISSZ),
    .ISSEEC    (ISSEEC),
    .pls_p     (pls_p),
    .pls_m     (pls_m),
    .cmd       (cmd_if)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_pass   = 0;
  ev_t  exp_q[$];
  bit   inh_s[NSLOT];
  bit   eec_s[NSLOT];
  int   model_rem = 0;

  task automatic check(input string name, input bit ok, input string detail);
    n_checks++;
    if (ok) n_pass++;
    else    $display("FAIL %s: %s", name, detail);
  endtask

  function automatic string ev_str(input ev_t e);
    return $sformatf("done=%0b cyc=%0d lines=%b width=%0d rem=%0d err=%0b",
                     e.is_done, e.cyc, e.vec, e.width, e.rem, e.err);
  endfunction

  task automatic compare_ev(input ev_t got);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", 1'b0, $sformatf("got %s, required no event", ev_str(got)));
      return;
    end
    e = exp_q.pop_front();
    check(got.is_done ? "done_event" : "pulse_event", got == e,
          $sformatf("got %s, required %s", ev_str(got), ev_str(e)));
  endtask

  // Monitor: reconstructs whole pulses and done strobes from the output lines.
  logic [5:0] prev_vec = '0;
  logic [5:0] cur_vec;
  int         p_start;
  logic [5:0] p_vec;
  int         p_rem;
  ev_t        got_ev;

  always @(negedge clk) begin
    cur_vec = {pls_m, pls_p};
    if (!rst_n) begin
      prev_vec = '0;
    end else begin
      if (cur_vec != '0 && prev_vec == '0) begin
        p_start = cyc;
        p_vec   = cur_vec;
        p_rem   = int'(cmd_if.remaining);
      end else if (cur_vec != '0 && cur_vec != prev_vec) begin
        check("pulse_lines_stable", 1'b0,
              $sformatf("got lines %b after %b, required unchanged", cur_vec, prev_vec));
      end
      if (cur_vec == '0 && prev_vec != '0) begin
        got_ev = '{is_done: 1'b0, cyc: p_start, vec: p_vec, width: cyc - p_start,
                   rem: p_rem, err: 1'b0};
        compare_ev(got_ev);
      end
      if (cmd_if.done) begin
        got_ev = '{is_done: 1'b1, cyc: cyc, vec: 6'b0, width: 0,
                   rem: int'(cmd_if.remaining), err: cmd_if.err};
        compare_ev(got_ev);
      end else if (cmd_if.err) begin
        check("err_without_done", 1'b0, "got err=1 with done=0, required err only with done");
      end
      prev_vec = cur_vec;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running, required completion");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input logic d, input int c, input logic [5:0] v, input int w,
                         input int rem, input logic e);
    ev_t x;
    x = '{is_done: d, cyc: c, vec: v, width: w, rem: rem, err: e};
    exp_q.push_back(x);
  endtask

  // Command rejected or empty: single done strobe one clock after the offer.
  task automatic run_reject(input int axis, input int mag);
    push_ev(1'b1, cyc + 1, 6'b0, 0, model_rem, axis == 3);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_axis  = 2'(axis);
    cmd_if.cmd_neg   = 1'($urandom_range(0, 1));
    cmd_if.cmd_mag   = 15'(mag);
    step();
    cmd_if.cmd_valid = 1'b0;
    step();
  endtask

  // Model: slot k starts at accept+1+k*SLOT; a slot fires unless inhibited.
  // Pulses up to the abort cycle survive; done lands at the end of the abort slot.
  task automatic run_cmd(input int axis, input bit neg, input int mag, input bit ab_en,
                         input int ab_fixed);
    int fires[$];
    int a, last, ab_r, done_r, np;
    logic [5:0] vec;
    for (int k = 0; k < NSLOT && fires.size() < mag; k++)
      if (!inh_s[k] && !eec_s[k]) fires.push_back(k);
    last   = fires[fires.size() - 1];
    ab_r   = !ab_en ? SLOT * (last + 1) - 1 :
             (ab_fixed >= 0) ? ab_fixed : $urandom_range(0, SLOT * (last + 1) - 1);
    done_r = SLOT * (ab_r / SLOT + 1);
    vec    = 6'b000001 << (neg ? axis + 3 : axis);
    a      = cyc + 1;
    np     = 0;
    foreach (fires[i]) begin
      if (SLOT * fires[i] <= ab_r) begin
        push_ev(1'b0, a + SLOT * fires[i], vec, PW, mag - np, 1'b0);
        np++;
      end
    end
    model_rem = mag - np;
    push_ev(1'b1, a + done_r, 6'b0, 0, model_rem, 1'b0);

    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_axis  = 2'(axis);
    cmd_if.cmd_neg   = neg;
    cmd_if.cmd_mag   = 15'(mag);
    for (int r = 0; r <= done_r; r++) begin
      step();
      cmd_if.cmd_valid = 1'b0;
      UINHRC           = (r % SLOT == 0) ? inh_s[r / SLOT] : 1'($urandom_range(0, 1));
      cmd_if.cmd_abort = ab_en && (r == ab_r);
      disc_we          = 1'b0;
      if (r % SLOT == SLOT - 1 && r / SLOT + 1 < NSLOT && eec_s[r / SLOT + 1]) begin
        disc_we   = 1'b1;
        disc_data = 3'b010;
      end else if (r % SLOT == 1 && eec_s[r / SLOT]) begin
        disc_we   = 1'b1;
        disc_data = 3'b110;
      end
    end
    step();
    UINHRC           = 1'b0;
    cmd_if.cmd_abort = 1'b0;
    disc_we          = 1'b1;
    disc_data        = 3'b110;
    step();
    disc_we = 1'b0;
  endtask

  task automatic clear_gates();
    for (int k = 0; k < NSLOT; k++) begin
      inh_s[k] = 1'b0;
      eec_s[k] = 1'b0;
    end
  endtask

  initial begin
    int zcount;
    bit ready_leak;
    rst_n            = 1'b0;
    disc_we          = 1'b0;
    disc_data        = 3'b000;
    UINHRC           = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_axis  = 2'd0;
    cmd_if.cmd_neg   = 1'b0;
    cmd_if.cmd_mag   = 15'd0;
    cmd_if.cmd_abort = 1'b0;
    clear_gates();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset_state",
          {ISSCA, ISSZ, ISSEEC, pls_p, pls_m, cmd_if.remaining, cmd_if.done, cmd_if.err} == '0
          && cmd_if.cmd_ready,
          $sformatf("got ca=%b z=%b eec=%b p=%b m=%b rem=%0d done=%b err=%b ready=%b, required 0s, ready=1",
                    ISSCA, ISSZ, ISSEEC, pls_p, pls_m, cmd_if.remaining, cmd_if.done,
                    cmd_if.err, cmd_if.cmd_ready));

    disc_we   = 1'b1;
    disc_data = 3'b110;
    check("disc_latency", !ISSEEC && !ISSCA,
          $sformatf("got eec=%b ca=%b before edge, required 0 0", ISSEEC, ISSCA));
    step();
    disc_we = 1'b0;
    check("disc_write", ISSEEC && ISSCA && !ISSZ,
          $sformatf("got eec=%b ca=%b z=%b, required 1 1 0", ISSEEC, ISSCA, ISSZ));

    // Zero request collides with an offered illegal command: zero must win.
    disc_we          = 1'b1;
    disc_data        = 3'b111;
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_axis  = 2'd3;
    cmd_if.cmd_mag   = 15'd1;
    step();
    disc_we          = 1'b0;
    cmd_if.cmd_valid = 1'b0;
    zcount     = 0;
    ready_leak = 1'b0;
    for (int i = 0; i < 200 && ISSZ; i++) begin
      zcount++;
      if (cmd_if.cmd_ready) ready_leak = 1'b1;
      step();
    end
    check("zero_width", zcount == ZC, $sformatf("got %0d clocks of ISSZ, required %0d", zcount, ZC));
    check("zero_ready_low", !ready_leak, "got cmd_ready=1 during ISSZ, required 0");
    check("zero_ready_after", cmd_if.cmd_ready,
          $sformatf("got cmd_ready=%b after zero, required 1", cmd_if.cmd_ready));

    run_reject(3, 7);
    run_reject(1, 0);

    run_cmd(0, 1'b0, 3, 1'b0, -1);
    inh_s[2] = 1'b1;
    inh_s[3] = 1'b1;
    run_cmd(2, 1'b1, 5, 1'b0, -1);
    clear_gates();
    run_cmd(1, 1'b0, 100, 1'b1, 3 * SLOT + 1);
    run_reject(0, 0);

    for (int n = 0; n < 20; n++) begin
      int sel;
      sel = $urandom_range(0, 7);
      if (sel == 0) begin
        run_reject(3, $urandom_range(0, 9));
      end else if (sel == 1) begin
        run_reject($urandom_range(0, 2), 0);
      end else begin
        clear_gates();
        for (int k = 0; k < 24; k++) begin
          inh_s[k] = ($urandom_range(0, 3) == 0);
          eec_s[k] = (k > 0) && ($urandom_range(0, 7) == 0);
        end
        run_cmd($urandom_range(0, 2), 1'($urandom_range(0, 1)), $urandom_range(1, 6),
                $urandom_range(0, 2) == 0, -1);
      end
    end

    // Reset while a pulse is on the line must cut it and restore reset values.
    clear_gates();
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_axis  = 2'd0;
    cmd_if.cmd_neg   = 1'b0;
    cmd_if.cmd_mag   = 15'd5;
    step();
    cmd_if.cmd_valid = 1'b0;
    check("pulse_before_reset", pls_p == 3'b001,
          $sformatf("got pls_p=%b, required 001", pls_p));
    rst_n = 1'b0;
    step();
    check("reset_mid_pulse",
          {ISSCA, ISSZ, ISSEEC, pls_p, pls_m, cmd_if.remaining, cmd_if.done, cmd_if.err} == '0
          && cmd_if.cmd_ready,
          $sformatf("got p=%b m=%b eec=%b rem=%0d ready=%b, required 0s, ready=1",
                    pls_p, pls_m, ISSEEC, cmd_if.remaining, cmd_if.cmd_ready));
    rst_n = 1'b1;
    repeat (4) step();
    check("scoreboard_drained", exp_q.size() == 0,
          $sformatf("got %0d pending events, required 0", exp_q.size()));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
